// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, exception codes,
// funct3 access encodings and request legality helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_BUS      = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned accesses only make sense for loads; everything else outside
    // the five encodings is reserved.
    function automatic logic type_illegal(input logic rw, input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = rw;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Natural alignment check for halfword and word accesses.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and lane
// replication, plus load lane selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  type_access,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [15:0] lane;

    // Bring the addressed byte/halfword down to bit 0; off=3 only matters for bytes.
    always_comb begin
        lane = 16'h0000;
        case (off)
            2'd0: lane = rdata[15:0];
            2'd1: lane = rdata[23:8];
            2'd2: lane = rdata[31:16];
            2'd3: lane = {8'h00, rdata[31:24]};
            default: lane = 16'h0000;
        endcase
    end

    // Enables, replicated store data and extended load data per access type.
    always_comb begin
        be      = 4'b0000;
        wdata   = 32'h0000_0000;
        ld_data = 32'h0000_0000;
        case (type_access)
            F3_B: begin
                be      = 4'b0001 << off;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{lane[7]}}, lane[7:0]};
            end
            F3_BU: begin
                be      = 4'b0001 << off;
                wdata   = {4{st_data[7:0]}};
                ld_data = {24'h000000, lane[7:0]};
            end
            F3_H: begin
                be      = 4'b0011 << off;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{lane[15]}}, lane};
            end
            F3_HU: begin
                be      = 4'b0011 << off;
                wdata   = {2{st_data[15:0]}};
                ld_data = {16'h0000, lane};
            end
            F3_W: begin
                be      = 4'b1111;
                wdata   = st_data;
                ld_data = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between decode and the data-memory request/grant/response
// bus. Stalls the core while a transaction is in flight and reports
// misaligned, illegal-type and (optionally) bus-timeout exceptions.
// Optional feature: define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYC cycles.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
)(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_mem_rw,
    input  logic [2:0]  i_type_access,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_done,
    output logic        o_busy,
    output logic [1:0]  o_exc,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    state_t      state_q, state_d;
    logic        rw_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] st_q;
    logic [31:0] ld_q;
    logic [1:0]  exc_q;
    logic        timeout;
    logic        req_bad;
    logic [1:0]  req_exc;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    // Classify the incoming request; illegal type wins over misalignment.
    always_comb begin
        req_exc = EXC_NONE;
        if (type_illegal(i_mem_rw, i_type_access)) begin
            req_exc = EXC_ILLEGAL;
        end else if (misaligned(i_type_access, i_addr[1:0])) begin
            req_exc = EXC_MISALIGN;
        end
    end

    assign req_bad = (req_exc != EXC_NONE);

    lsu_align u_align (
        .type_access (type_q),
        .off         (addr_q[1:0]),
        .st_data     (st_q),
        .rdata       (i_mem_rdata),
        .be          (al_be),
        .wdata       (al_wdata),
        .ld_data     (al_ld)
    );

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);
    // Fires in the cycle whose increment would reach the limit, so the unit
    // spends exactly TIMEOUT_CYC cycles in REQ+WAIT.
    assign timeout = ((state_q == REQ) || (state_q == WAIT)) &&
                     (cnt_inc == CNT_W'(TIMEOUT_CYC));

    // Cycle counter: cleared on entering REQ, counts through REQ and WAIT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && (state_d == REQ)) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_q <= cnt_inc;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC[0], CNT_W[0]};
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a timeout overrides any gnt/rvalid in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = req_bad ? DONE : REQ;
                end
            end
            REQ: begin
                if (timeout) begin
                    state_d = DONE;
                end else if (i_mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timeout || i_mem_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches, exception code and captured load data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rw_q   <= 1'b0;
            type_q <= 3'b000;
            addr_q <= 32'h0000_0000;
            st_q   <= 32'h0000_0000;
            ld_q   <= 32'h0000_0000;
            exc_q  <= EXC_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        rw_q   <= i_mem_rw;
                        type_q <= i_type_access;
                        addr_q <= i_addr;
                        st_q   <= i_st_data;
                        ld_q   <= 32'h0000_0000;
                        exc_q  <= req_exc;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        exc_q <= EXC_BUS;
                        ld_q  <= 32'h0000_0000;
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        exc_q <= EXC_BUS;
                        ld_q  <= 32'h0000_0000;
                    end else if (i_mem_rvalid) begin
                        ld_q <= rw_q ? 32'h0000_0000 : al_ld;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = o_mem_req & rw_q;
    assign o_mem_addr  = o_mem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    assign o_mem_be    = o_mem_req ? al_be : 4'b0000;
    assign o_mem_wdata = o_mem_we ? al_wdata : 32'h0000_0000;
    assign o_done      = (state_q == DONE);
    assign o_exc       = o_done ? exc_q : EXC_NONE;
    assign o_ld_data   = o_done ? ld_q : 32'h0000_0000;
    assign o_busy      = (state_q == REQ) || (state_q == WAIT) ||
                         ((state_q == IDLE) && i_req);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: a table of single transactions with
// hand-computed results, plus sequences for mid-transaction reset and a
// grant that never arrives.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req = 1'b0;
    logic        i_mem_rw = 1'b0;
    logic [2:0]  i_type_access = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_st_data = 32'h0;
    logic [31:0] o_ld_data;
    logic        o_done;
    logic        o_busy;
    logic [1:0]  o_exc;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_req         (i_req),
        .i_mem_rw      (i_mem_rw),
        .i_type_access (i_type_access),
        .i_addr        (i_addr),
        .i_st_data     (i_st_data),
        .o_ld_data     (o_ld_data),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_exc         (o_exc),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_be      (o_mem_be),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata)
    );

    typedef struct {
        string       nm;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rd;
        int          gdly;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        logic [1:0]  exc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rw, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] st,
                                input logic [31:0] rd, input int gdly, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld,
                                input logic [1:0] exc);
        vec_t v;
        v.nm = nm; v.rw = rw; v.f3 = f3; v.addr = addr; v.st = st; v.rd = rd;
        v.gdly = gdly; v.be = be; v.wd = wd; v.ld = ld; v.exc = exc;
        return v;
    endfunction

    task automatic drive_req(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] st, input logic [31:0] rd);
        i_req = 1'b1; i_mem_rw = rw; i_type_access = f3;
        i_addr = addr; i_st_data = st; i_mem_rdata = rd;
    endtask

    // One transaction: memory grants after gdly request cycles and answers
    // the cycle after the grant.
    task automatic run_vec(input vec_t v);
        int ncyc = 0, req_cyc = 0, done_cyc = 0;
        logic granted = 1'b0, done_seen = 1'b0, busy_ok = 1'b1, held_ok = 1'b1;
        logic busy_at_done = 1'b0, we_s = 1'b0;
        logic [3:0] be_s = 4'h0;
        logic [31:0] addr_s = 0, wd_s = 0, ld_s = 0;
        logic [1:0] exc_s = 2'b00;
        int exp_req = (v.exc != 2'b00) ? 0 : v.gdly + 1;
        int exp_done = (v.exc != 2'b00) ? 1 : v.gdly + 3;
        @(negedge clk);
        drive_req(v.rw, v.f3, v.addr, v.st, v.rd);
        #1;
        check({v.nm, "_busy_on_req"}, 32'(o_busy), 32'd1);
        while (!done_seen && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            i_mem_gnt = 1'b0;
            i_mem_rvalid = 1'b0;
            if (o_done) begin
                done_seen = 1'b1; done_cyc = ncyc; ld_s = o_ld_data;
                exc_s = o_exc; busy_at_done = o_busy; i_req = 1'b0;
            end else begin
                if (!o_busy) busy_ok = 1'b0;
                if (o_mem_req) begin
                    if (req_cyc == 0) begin
                        we_s = o_mem_we; addr_s = o_mem_addr; be_s = o_mem_be; wd_s = o_mem_wdata;
                    end else if ({o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !==
                                 {we_s, addr_s, be_s, wd_s}) begin
                        held_ok = 1'b0;
                    end
                    req_cyc++;
                    if (req_cyc > v.gdly) begin
                        i_mem_gnt = 1'b1;
                        granted = 1'b1;
                    end
                end else if (granted) begin
                    i_mem_rvalid = 1'b1;
                end
            end
        end
        i_req = 1'b0;
        check({v.nm, "_done_seen"}, 32'(done_seen), 32'd1);
        check({v.nm, "_done_cycle"}, done_cyc, exp_done);
        check({v.nm, "_exc"}, 32'(exc_s), 32'(v.exc));
        check({v.nm, "_ld_data"}, ld_s, v.ld);
        check({v.nm, "_req_cycles"}, req_cyc, exp_req);
        check({v.nm, "_busy_until_done"}, 32'(busy_ok), 32'd1);
        check({v.nm, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        if (v.exc == 2'b00) begin
            check({v.nm, "_be"}, 32'(be_s), 32'(v.be));
            check({v.nm, "_addr"}, addr_s, {v.addr[31:2], 2'b00});
            check({v.nm, "_we"}, 32'(we_s), 32'(v.rw));
            check({v.nm, "_req_held"}, 32'(held_ok), 32'd1);
            if (v.rw) check({v.nm, "_wdata"}, wd_s, v.wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        int req_cyc;
        logic done_seen;
        logic ok;
        logic [1:0] exc_s;
        logic [31:0] ld_s;

        vecs.push_back(mk("lb_103",    0, 3'b000, 32'h103, 32'h0,         32'h80FF_1234, 0, 4'b1000, 32'h0,         32'hFFFF_FF80, 2'b00));
        vecs.push_back(mk("sh_202",    1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0,         2, 4'b1100, 32'hBEEF_BEEF, 32'h0,         2'b00));
        vecs.push_back(mk("lhu_301",   0, 3'b101, 32'h301, 32'h0,         32'hFFFF_FFFF, 0, 4'b0000, 32'h0,         32'h0,         2'b01));
        vecs.push_back(mk("st_t100",   1, 3'b100, 32'h204, 32'h1111_2222, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         2'b10));
        vecs.push_back(mk("ld_t011",   0, 3'b011, 32'h208, 32'h0,         32'hAAAA_5555, 0, 4'b0000, 32'h0,         32'h0,         2'b10));
        vecs.push_back(mk("ld_t110",   0, 3'b110, 32'h20C, 32'h0,         32'hAAAA_5555, 0, 4'b0000, 32'h0,         32'h0,         2'b10));
        vecs.push_back(mk("st_t101",   1, 3'b101, 32'h210, 32'h3333_4444, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         2'b10));
        vecs.push_back(mk("lw_400",    0, 3'b010, 32'h400, 32'h0,         32'h1234_5678, 1, 4'b1111, 32'h0,         32'h1234_5678, 2'b00));
        vecs.push_back(mk("lh_402",    0, 3'b001, 32'h402, 32'h0,         32'h8001_7FFF, 0, 4'b1100, 32'h0,         32'hFFFF_8001, 2'b00));
        vecs.push_back(mk("lh_000",    0, 3'b001, 32'h000, 32'h0,         32'h1234_8765, 0, 4'b0011, 32'h0,         32'hFFFF_8765, 2'b00));
        vecs.push_back(mk("lbu_501",   0, 3'b100, 32'h501, 32'h0,         32'h0000_A500, 0, 4'b0010, 32'h0,         32'h0000_00A5, 2'b00));
        vecs.push_back(mk("lhu_002",   0, 3'b101, 32'h002, 32'h0,         32'hF00D_1234, 0, 4'b1100, 32'h0,         32'h0000_F00D, 2'b00));
        vecs.push_back(mk("lb_pos",    0, 3'b000, 32'h000, 32'h0,         32'h0000_007F, 0, 4'b0001, 32'h0,         32'h0000_007F, 2'b00));
        vecs.push_back(mk("sb_003",    1, 3'b000, 32'h003, 32'h1234_56AB, 32'h0,         0, 4'b1000, 32'hABAB_ABAB, 32'h0,         2'b00));
        vecs.push_back(mk("sw_10c",    1, 3'b010, 32'h10C, 32'hCAFE_F00D, 32'h0,         1, 4'b1111, 32'hCAFE_F00D, 32'h0,         2'b00));
        vecs.push_back(mk("sw_mis",    1, 3'b010, 32'h102, 32'h5555_6666, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         2'b01));
        vecs.push_back(mk("lw_mis",    0, 3'b010, 32'h001, 32'h0,         32'h7777_8888, 0, 4'b0000, 32'h0,         32'h0,         2'b01));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        check("reset_outputs",
              32'({o_done, o_busy, o_mem_req, o_mem_we, o_exc, o_mem_be} != 0 ||
                  o_ld_data != 0 || o_mem_addr != 0 || o_mem_wdata != 0), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while waiting for the response, followed by stray rvalid pulses
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h700, 32'h0, 32'h9999_9999);
        @(negedge clk);
        check("rstmid_in_req", 32'(o_mem_req), 32'd1);
        i_mem_gnt = 1'b1;
        @(negedge clk);
        i_mem_gnt = 1'b0;
        check("rstmid_in_wait", 32'({o_mem_req, o_busy}), 32'b01);
        i_reset = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        check("rstmid_outputs_zero",
              32'({o_done, o_busy, o_mem_req, o_mem_we, o_exc, o_mem_be} != 0 ||
                  o_ld_data != 0 || o_mem_addr != 0 || o_mem_wdata != 0), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_mem_rvalid = 1'b1;
            @(negedge clk);
            if (o_done || o_busy || o_mem_req || o_ld_data != 0) ok = 1'b0;
        end
        i_mem_rvalid = 1'b0;
        check("rstmid_rvalid_ignored", 32'(ok), 32'd1);

        // Grant never arrives
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h600, 32'h0, 32'h4444_4444);
        ncyc = 0; req_cyc = 0; done_seen = 1'b0; ok = 1'b1; exc_s = 2'b00; ld_s = 0;
`ifdef LSU_TIMEOUT_EN
        while (!done_seen && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (o_done) begin
                done_seen = 1'b1; exc_s = o_exc; ld_s = o_ld_data; i_req = 1'b0;
            end else if (o_mem_req) begin
                req_cyc++;
            end
        end
        i_req = 1'b0;
        check("tmo_done_seen", 32'(done_seen), 32'd1);
        check("tmo_req_cycles", req_cyc, 4);
        check("tmo_done_cycle", ncyc, 5);
        check("tmo_exc", 32'(exc_s), 32'd3);
        check("tmo_ld_data", ld_s, 32'h0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_busy || o_done || !o_mem_req) ok = 1'b0;
        end
        check("nogrant_busy_held", 32'(ok), 32'd1);
        i_mem_gnt = 1'b1;
        @(negedge clk);
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b1;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        check("nogrant_late_done", 32'(o_done), 32'd1);
        check("nogrant_late_exc", 32'(o_exc), 32'd0);
        check("nogrant_late_ld", o_ld_data, 32'h4444_4444);
        i_req = 1'b0;
`endif
        @(negedge clk);
        check("final_idle", 32'({o_done, o_busy, o_mem_req}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit that sits directly downstream of the decoder. It consumes the memory-write flag and the 3-bit access type (funct3) from decode, plus the ALU-computed address and the rs2 data.
- It drives a request/grant/response data-memory bus and returns aligned, sign- or zero-extended load data to the writeback mux.
- It stalls the core with o_busy while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in REQ+WAIT before a bus error is raised. Used only with LSU_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter; TIMEOUT_CYC must be less than 2^CNT_W.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  1  load/store request from core; held stable until o_done.
- i_mem_rw  in  1  0 = load, 1 = store.
- i_type_access  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  32  byte address from ALU.
- i_st_data  in  32  store data (rs2).
- o_ld_data  out  32  extended load data; valid while o_done=1.
- o_done  out  1  1-cycle completion pulse.
- o_busy  out  1  stall request to the core.
- o_exc  out  2  00 none, 01 misaligned, 10 illegal type, 11 bus error; valid with o_done.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  32  word address {addr[31:2], 2'b00}.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_gnt  in  1  request accepted.
- i_mem_rvalid  in  1  response or write acknowledge.
- i_mem_rdata  in  32  read word.

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values: state=IDLE; every output is 0; latched request fields are 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On i_req=1, latch rw, type, addr and st_data.
  - Illegal type goes to DONE with o_exc=10. Illegal types are 011/110/111 for any access, and 100/101 for stores.
  - Misaligned access goes to DONE with o_exc=01. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - Otherwise go to REQ.
  - No memory request is issued for any exception.
- REQ:
  - o_mem_req=1 with o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata held constant.
  - i_mem_gnt=1 goes to WAIT; o_mem_req drops in the next cycle.
- WAIT:
  - i_mem_rvalid=1 goes to DONE.
  - For loads, register the extracted data at that edge.
  - Stores also wait for rvalid, which acts as the write ack.
- DONE: o_done=1 for exactly one cycle, then IDLE. i_req is ignored in DONE.
- i_mem_rvalid outside WAIT is ignored. Memory must not assert rvalid in the grant cycle.
- o_busy = (state==REQ) | (state==WAIT) | (state==IDLE & i_req). This output is combinational.
- Minimum latency: i_req at cycle 0, REQ at cycle 1 (gnt), WAIT at cycle 2 (rvalid), o_done at cycle 3.
- Byte enables, with off=addr[1:0]:
  - B/BU: 4'b0001<<off.
  - H/HU: 4'b0011<<off.
  - W: 4'b1111.
  - Loads drive the same be pattern.
- Write data: SB replicates byte[7:0] to all four lanes; SH replicates [15:0] to both halves; SW passes through.
- Load extraction: select lane by off. B/H sign-extend; BU/HU zero-extend.
- o_ld_data is 0 for stores and for exceptions.
- Reset asserted mid-transaction returns to IDLE and zeroes all outputs. Any pending response is dropped; the memory shares the same reset.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT_CYC, go to DONE with o_exc=11. o_mem_req drops and o_ld_data=0.
  - A gnt or rvalid arriving in that same cycle is ignored.
- Undefined: no counter. The unit waits indefinitely and o_exc never equals 11.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - exception code localparams;
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_align (purely combinational) generates be/wdata from type+off+st_data and performs load extract/extend from type+off+rdata.
- The FSM, latches and timeout counter stay in lsu_mem_ctrl.

Test Plan:
- LB at 0x103, rdata=0x80FF_1234, gnt and rvalid each with zero wait: o_mem_addr=0x100, be=1000, o_done at cycle 3, o_ld_data=0xFFFF_FF80, o_exc=00.
- SH at 0x202, st_data=0xDEAD_BEEF, gnt delayed 2 cycles: o_mem_req held 3 cycles with we=1, be=1100, wdata=0xBEEF_BEEF; o_busy=1 until the DONE cycle.
- LHU at 0x301: o_exc=01 one cycle later, o_mem_req never asserted, o_ld_data=0.
- Store with type 100, and load with type 011: o_exc=10 for both, no memory request.
- i_reset asserted while in WAIT, then rvalid pulses: state=IDLE, o_done stays 0, all outputs 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, gnt never asserted: o_done with o_exc=11 after 4 REQ cycles; without the macro, o_busy stays 1.
